// File: rtl/prog_loader.sv
// Program-image loader: turns a framed byte stream into 12-bit instruction
// writes at sequential addresses and validates a trailing checksum byte.
module prog_loader #(
    parameter int DEPTH  = 10,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              load_le,
    output logic [ADDR_W-1:0] load_addr,
    output logic [11:0]       load_instr,
    output logic              load_done,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_WR   = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        SYNC      = 4'hA;

    // Image is valid when the running sum plus the check byte wraps to zero.
    function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] c);
        logic [7:0] total;
        total = sum + c;
        return (total == 8'h00);
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          sum_q, sum_d;
    logic [3:0]          hi_q, hi_d;
    logic [11:0]         instr_q, instr_d;
    logic                ready_q, ready_d;
    logic                le_q, le_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                accept_s;
    logic                last_s;

    // ready_q mirrors the current state, so this is a pure state-qualified handshake
    assign accept_s = byte_valid && ready_q;
    assign last_s   = (addr_q == LAST_ADDR);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start overrides everything, including a same-cycle byte
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_HI;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_HI: begin
                    if (accept_s) begin
                        state_d = (byte_in[7:4] == SYNC) ? S_LO : S_ERR;
                    end else begin
                        state_d = S_HI;
                    end
                end
                S_LO: begin
                    if (accept_s) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_LO;
                    end
                end
                S_WR:   state_d = last_s ? S_CSUM : S_HI;
                S_CSUM: begin
                    if (accept_s) begin
                        state_d = csum_ok(sum_q, byte_in) ? S_DONE : S_ERR;
                    end else begin
                        state_d = S_CSUM;
                    end
                end
                S_DONE:  state_d = S_DONE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values: address, checksum, and word assembly
    always_comb begin
        addr_d  = addr_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        instr_d = instr_q;
        if (start) begin
            addr_d = {ADDR_W{1'b0}};
            sum_d  = 8'h00;
        end else if (state_q == S_HI && accept_s) begin
            hi_d  = byte_in[3:0];
            sum_d = sum_q + byte_in;
        end else if (state_q == S_LO && accept_s) begin
            // load_instr only changes on entry to WR, so it is stable elsewhere
            instr_d = {hi_q, byte_in};
            sum_d   = sum_q + byte_in;
        end else if (state_q == S_WR && !last_s) begin
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            addr_d = addr_q;
        end
    end

    // Output decode from the upcoming state so outputs can be registered
    always_comb begin
        ready_d = 1'b0;
        le_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            S_IDLE: busy_d = 1'b0;
            S_HI, S_LO, S_CSUM: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_WR: begin
                le_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            S_ERR:   err_d  = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= {ADDR_W{1'b0}};
            sum_q   <= 8'h00;
            hi_q    <= 4'h0;
            instr_q <= 12'h000;
            ready_q <= 1'b0;
            le_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            instr_q <= instr_d;
            ready_q <= ready_d;
            le_q    <= le_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign byte_ready = ready_q;
    assign load_le    = le_q;
    assign load_addr  = addr_q;
    assign load_instr = instr_q;
    assign load_done  = done_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: images are scored against a byte-level
// model of the framing and checksum rules.
module tb_prog_loader;

    localparam int DEPTH  = 10;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              load_le;
    logic [ADDR_W-1:0] load_addr;
    logic [11:0]       load_instr;
    logic              load_done;
    logic              busy;
    logic              err;

    prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .load_le(load_le),
        .load_addr(load_addr), .load_instr(load_instr), .load_done(load_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [11:0]       w;
    } wr_t;

    logic [7:0] img_q[$];
    wr_t        exp_q[$];
    int         exp_bytes, exp_nwr, exp_cyc;
    bit         exp_done, exp_err;
    int         strobe_n = 0;

    // Reference: walk the byte image applying the framing/checksum rules
    task automatic model_image();
        int s;
        logic [7:0] h, l, c;
        wr_t e;
        exp_q.delete();
        exp_bytes = 0; exp_nwr = 0; exp_done = 0; exp_err = 0; s = 0;
        for (int w = 0; w < DEPTH; w++) begin
            h = img_q[2*w];
            s += int'(h);
            exp_bytes++;
            if (h[7:4] != 4'hA) begin
                exp_err = 1;
                exp_cyc = 3*w + 1;
                return;
            end
            l = img_q[2*w+1];
            s += int'(l);
            exp_bytes++;
            e.a = ADDR_W'(w);
            e.w = {h[3:0], l};
            exp_q.push_back(e);
            exp_nwr++;
        end
        c = img_q[2*DEPTH];
        exp_bytes++;
        exp_cyc = 3*DEPTH + 1;
        if (((s + int'(c)) % 256) == 0) exp_done = 1;
        else exp_err = 1;
    endtask

    task automatic build_image(input logic [11:0] base, input bit rnd, input int delta, input int bad_idx);
        logic [11:0] word;
        logic [7:0]  s8, hb, lb;
        s8 = 8'h00;
        img_q.delete();
        for (int w = 0; w < DEPTH; w++) begin
            word = rnd ? 12'($urandom) : base + 12'(w);
            hb = {4'hA, word[11:8]};
            lb = word[7:0];
            img_q.push_back(hb);
            img_q.push_back(lb);
            s8 = s8 + hb + lb;
        end
        img_q.push_back(8'h00 - s8 + 8'(delta));
        if (bad_idx >= 0) img_q[bad_idx] = 8'h5F;
    endtask

    // Strobe scoreboard
    always @(negedge clk) begin
        if (load_le) begin
            strobe_n++;
            check_val("ready_in_wr", 32'(byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", 32'(strobe_n), 32'(exp_nwr));
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_val("addr", 32'(load_addr), 32'(e.a));
                check_val("instr", 32'(load_instr), 32'(e.w));
            end
        end
    end

    task automatic run_image(input int pct, input int stop_strobes, output int acc, output int fin_cyc);
        int idx, ls;
        bit v;
        idx = 0; ls = 0; acc = 0; fin_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        model_image();
        strobe_n = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (load_done || err) begin
                fin_cyc = cyc;
                break;
            end
            if (load_le) begin
                ls++;
                if (stop_strobes > 0 && ls == stop_strobes) break;
            end
            v = ($urandom_range(99) < 32'(pct)) && (idx < img_q.size());
            byte_valid = v;
            byte_in = v ? img_q[idx] : 8'($urandom);
            if (v && byte_ready) begin
                idx++;
                acc++;
            end
            @(negedge clk);
        end
        if (fin_cyc >= 0) begin
            for (int k = 0; k < 3; k++) begin
                byte_valid = 1'b1;
                byte_in = 8'($urandom);
                if (byte_ready) acc++;
                @(negedge clk);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic end_checks(input int acc, input int fin_cyc, input bit full);
        check_val("done", 32'(load_done), 32'(exp_done));
        check_val("err", 32'(err), 32'(exp_err));
        check_val("bytes_taken", 32'(acc), 32'(exp_bytes));
        check_val("strobe_count", 32'(strobe_n), 32'(exp_nwr));
        check_val("ready_final", 32'(byte_ready), 32'd0);
        check_val("busy_final", 32'(busy), 32'd0);
        if (full) check_val("latency", 32'(fin_cyc), 32'(exp_cyc));
        else check_val("finished", 32'(fin_cyc >= 0), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check_val({tag, "_le"}, 32'(load_le), 32'd0);
        check_val({tag, "_addr"}, 32'(load_addr), 32'd0);
        check_val({tag, "_instr"}, 32'(load_instr), 32'd0);
        check_val({tag, "_done"}, 32'(load_done), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int acc, fc;
        #1 rst = 1'b0;
        #1 reset_checks("rst0");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_checks("idle");

        // Nominal image 001..00A at full rate
        build_image(12'h001, 1'b0, 0, -1);
        run_image(100, 0, acc, fc);
        end_checks(acc, fc, 1'b1);

        // Bad sync marker on H byte of word 1
        build_image(12'h001, 1'b0, 0, 2);
        run_image(100, 0, acc, fc);
        end_checks(acc, fc, 1'b1);

        // Checksum off by one
        build_image(12'h001, 1'b0, 1, -1);
        run_image(100, 0, acc, fc);
        end_checks(acc, fc, 1'b1);

        // Nominal image with 50% valid gaps
        build_image(12'h001, 1'b0, 0, -1);
        run_image(50, 0, acc, fc);
        end_checks(acc, fc, 1'b0);

        // Random images, random rate, occasional faults
        for (int t = 0; t < 6; t++) begin
            int delta, bad;
            delta = ($urandom_range(3) == 0) ? 1 : 0;
            bad = ($urandom_range(3) == 0) ? 2 * int'($urandom_range(DEPTH-1)) : -1;
            build_image(12'h000, 1'b1, delta, bad);
            run_image(int'($urandom_range(100, 30)), 0, acc, fc);
            end_checks(acc, fc, 1'b0);
        end

        // Restart after word 4, then a full new image F00..F09
        build_image(12'h123, 1'b0, 0, -1);
        run_image(100, 4, acc, fc);
        build_image(12'hF00, 1'b0, 0, -1);
        run_image(70, 0, acc, fc);
        end_checks(acc, fc, 1'b0);

        // Asynchronous reset during LO of word 6
        build_image(12'h040, 1'b0, 0, -1);
        run_image(100, 5, acc, fc);
        byte_valid = 1'b1;
        byte_in = img_q[10];
        @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
        check_val("busy_before_rst", 32'(busy), 32'd1);
        check_val("ready_in_lo", 32'(byte_ready), 32'd1);
        #2 rst = 1'b0;
        #1 reset_checks("async");
        @(negedge clk);
        @(negedge clk);
        reset_checks("held");
        rst = 1'b1;
        @(negedge clk);
        reset_checks("released");

        build_image(12'h000, 1'b1, 0, -1);
        run_image(100, 0, acc, fc);
        end_checks(acc, fc, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream program-image loader for the 8-bit microcontroller core. Accepts a byte stream over a valid/ready handshake, assembles 12-bit instruction words, and writes them one per strobe into program memory at sequential addresses. A trailing checksum byte validates the image before `load_done` releases the core from its LOAD stage. On a framing or checksum failure the loader reports an error and never asserts `load_done`.

## Interface

- `DEPTH`, 10, number of 12-bit instruction words per image (1..256).
- `ADDR_W`, 8, program-memory address width.

Ports:

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  single-cycle pulse; begins a new image load from any state.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` holds a valid byte.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `load_le`  out  1  program-memory write strobe, one cycle per word.
- `load_addr`  out  ADDR_W  write address for the current strobe.
- `load_instr`  out  12  instruction word for the current strobe.
- `load_done`  out  1  image written and checksum matched; held high.
- `busy`  out  1  high in every state except IDLE, DONE and ERR.
- `err`  out  1  framing or checksum failure; held high.

## Operation

- A byte is accepted only on a cycle where `byte_valid && byte_ready`. No other byte is consumed.
- Word framing uses two bytes:
  - Byte H: bits [7:4] must equal 4'hA (sync marker); bits [3:0] give instr[11:8].
  - Byte L: gives instr[7:0].
- Checksum: an 8-bit running sum, modulo 256, of every accepted H and L byte. After `DEPTH` words, one more byte C is accepted. C must equal the two's complement of the sum, so that (sum + C) mod 256 == 0.
- States:
  - IDLE: reset state. `start` moves to HI.
  - HI: `byte_ready`=1. On accept: if marker != 4'hA go to ERR; otherwise latch instr[11:8] and go to LO.
  - LO: `byte_ready`=1. On accept, latch instr[7:0] and go to WR.
  - WR: `byte_ready`=0 and `load_le`=1 for exactly one cycle. Next cycle: if `load_addr` == `DEPTH`-1, go to CSUM; otherwise increment `load_addr` and go to HI.
  - CSUM: `byte_ready`=1. On accept: if (sum + C) mod 256 == 0 go to DONE, else go to ERR.
  - DONE: `load_done`=1 until the next `start`.
  - ERR: `err`=1 until the next `start`.
- `start` in any state clears `load_addr`, the sum, `load_done` and `err`, then enters HI. A byte presented in the same cycle as `start` is not accepted.
- `load_addr` and `load_instr` are registered and stay stable outside WR. The sum is 8-bit and wraps silently.
- `start` during an in-progress load (mid-operation restart) discards the partial image. Words already written stay in memory but are overwritten by the new load.

## Timing

- Reset values: `byte_ready`=0, `load_le`=0, `load_addr`=0, `load_instr`=0, `load_done`=0, `busy`=0, `err`=0, state IDLE, sum 0.
- Reset asserted mid-load forces the reset values immediately (asynchronous). No further strobe is issued.
- `byte_ready` is a registered decode of state. It depends only on state, never on `byte_valid`.
- With `byte_valid` held high, each word takes 3 cycles (HI, LO, WR). A full image takes 3·`DEPTH`+1 cycles from the first HI cycle to entering DONE.
- `load_le` rises the cycle after the L byte is accepted.
- `load_done`/`err` rise the cycle after the C byte is accepted, or the cycle after a bad H byte is accepted.
- `byte_valid` gaps in HI, LO or CSUM stall the FSM indefinitely. There is no timeout.

## Test plan

- Nominal load: `DEPTH`=10, words 12'h001..12'h00A, correct C -> ten `load_le` pulses at addresses 0..9 with matching `load_instr`; `load_done`=1 at cycle 31 after first HI; `err`=0.
- Bad marker: third byte 8'h5F (H of word 1) -> `err`=1 the next cycle; only address 0 strobed; `byte_ready`=0 afterwards.
- Bad checksum: valid image with C off by 1 -> `err`=1, `load_done` stays 0, all 10 strobes still issued.
- Backpressure/gaps: `byte_valid` toggled randomly at 50% -> strobe sequence and final `load_done` identical to the nominal case; no byte is double-counted.
- Restart: `start` pulsed after word 4 is written, then a full new image (words 12'hF00..12'hF09) -> addresses restart at 0; `load_done`=1 with the new data.
- Async reset mid-load: `rst`=0 during LO of word 6 -> all outputs return to reset values without waiting for a clock edge; IDLE after release; `start` works normally.
